vga_raster_gen: RTL and testbench
=================================

Name: vga_raster_gen

Overview:
Raster timing generator that produces the pixel coordinates, active-video enable and sync pulses consumed by the overlay/drawing blocks such as the title-region painters. One horizontal counter and one vertical counter scan a full frame at one pixel per clk, and every output is registered. A run/stop controller starts scanning only at a frame origin and stops only at a frame boundary, so downstream blocks never see a partial frame.

Parameters:
H_ACTIVE, 800, visible pixels per line
H_FP, 40, horizontal front porch (pixels)
H_SYNC, 128, hsync width (pixels)
H_BP, 88, horizontal back porch (pixels); H_TOTAL = sum = 1056, must be ≤ 2048
V_ACTIVE, 600, visible lines per frame
V_FP, 1, vertical front porch (lines)
V_SYNC, 4, vsync width (lines)
V_BP, 23, vertical back porch (lines); V_TOTAL = sum = 628, must be ≤ 1024
SYNC_POL, 1'b1, active level of hsync and vsync

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous, active-low reset
run  in  1  level request to scan frames
gr_x  out  11  current horizontal count (0..H_TOTAL-1)
gr_y  out  10  current vertical count (0..V_TOTAL-1)
enable  out  1  high when gr_x < H_ACTIVE and gr_y < V_ACTIVE
hsync  out  1  horizontal sync, level SYNC_POL when asserted
vsync  out  1  vertical sync, level SYNC_POL when asserted
line_start  out  1  one-cycle pulse at gr_x==0 on an active line
frame_start  out  1  one-cycle pulse at gr_x==0, gr_y==0
busy  out  1  high in RUN or STOPPING

Behaviour:
- Reset (reset low, asynchronous): state IDLE, counters 0, gr_x=0, gr_y=0, enable=0, line_start=0, frame_start=0, busy=0, hsync=vsync=~SYNC_POL.
- State machine has three states: IDLE, RUN, STOPPING.
  - IDLE, run=1: go to RUN. Counters start at (0,0) on the next cycle.
  - RUN, run=0: go to STOPPING. Scanning continues unchanged.
  - STOPPING, run=1: go back to RUN with no gap in the scan.
  - STOPPING at the last pixel (h=H_TOTAL-1, v=V_TOTAL-1): go to IDLE, counters go to 0.
- Counters (RUN/STOPPING):
  - h increments every clk and wraps H_TOTAL-1 → 0.
  - v increments on the h wrap and wraps V_TOTAL-1 → 0.
  - In IDLE both counters hold at 0.
- Line segment order: active [0, H_ACTIVE-1], front porch, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], back porch. The vertical axis uses the same order in lines.
- Output timing:
  - All outputs are registered from the counter state, latency 1 clk. gr_x, gr_y, enable, syncs and pulses are mutually cycle-aligned.
  - The first frame_start appears 2 clks after run is sampled high in IDLE.
- Outputs while idle: enable, line_start and frame_start are 0 whenever busy=0. hsync and vsync stay inactive in IDLE.
- Arithmetic: comparisons are unsigned. Counter widths are fixed at 11/10 bits and no overflow is possible within the parameter limits.
- Reset asserted mid-frame: all outputs return to reset values immediately. After release, scanning restarts from (0,0) only via IDLE→RUN.

Optional Feature:
- Macro: VGA_RASTER_FRAME_CNT_EN
- Defined: adds output frame_cnt (8 bits).
  - Reset value 0.
  - Increments on the same cycle frame_start is asserted, wraps 255→0.
  - Holds its value in IDLE.
- Undefined: port and logic absent. All other behaviour is identical.

Test Plan:
- Release reset with run=1 → frame_start at cycle 2 with gr_x=0, gr_y=0, enable=1; enable falls when gr_x=800; hsync asserts for gr_x 840..967; line_start at gr_y=1 occurs 1056 clks after frame_start.
- Full frame → vsync asserted for gr_y 601..604; enable=0 for gr_y ≥ 600; next frame_start exactly 1056*628=663168 clks after the previous one.
- Drop run at gr_y=300 → busy stays 1 and the scan completes to (1055,627); the following cycle shows gr_x=0, gr_y=0, busy=0, no frame_start.
- Drop run at gr_y=300, then raise it at gr_y=500 → no interruption; next frame_start arrives exactly 663168 clks after the previous one.
- Assert reset at gr_x=400, gr_y=200 → outputs immediately reset (hsync=vsync=0 with SYNC_POL=1). Release with run=1 → frame_start 2 clks later.
- With VGA_RASTER_FRAME_CNT_EN defined, run 3 frames → frame_cnt 1, 2, 3 at each frame_start. Force 256 frames with a reduced-size parameter set → frame_cnt wraps to 0.

Source files
------------

// File: rtl/vga_raster_gen.sv
// vga_raster_gen: raster timing generator (pixel coordinates, active-video
// enable, sync pulses, line/frame pulses) with a run/stop controller that
// only starts at a frame origin and only stops at a frame boundary.
// Optional build macro VGA_RASTER_FRAME_CNT_EN adds an 8-bit frame counter.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | counters parked at (0,0), outputs quiet, waiting for run
// RUN      | scanning frames, run still requested
// STOPPING | run dropped, finishing the current frame before going idle

module vga_raster_gen #(
    parameter int   H_ACTIVE = 800,
    parameter int   H_FP     = 40,
    parameter int   H_SYNC   = 128,
    parameter int   H_BP     = 88,
    parameter int   V_ACTIVE = 600,
    parameter int   V_FP     = 1,
    parameter int   V_SYNC   = 4,
    parameter int   V_BP     = 23,
    parameter logic SYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    output logic [10:0] gr_x,
    output logic [9:0]  gr_y,
    output logic        enable,
    output logic        hsync,
    output logic        vsync,
    output logic        line_start,
    output logic        frame_start,
    output logic        busy
`ifdef VGA_RASTER_FRAME_CNT_EN
    ,
    output logic [7:0]  frame_cnt
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_S = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_E = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]  V_SYNC_S = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  V_SYNC_E = 10'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    state_t      state;
    logic [10:0] h_cnt;
    logic [9:0]  v_cnt;
    logic        scanning;
    logic        h_last;
    logic        v_last;
    logic        at_origin;

    assign scanning  = (state != IDLE);
    assign h_last    = (h_cnt == H_LAST);
    assign v_last    = (v_cnt == V_LAST);
    assign at_origin = scanning && (h_cnt == 11'd0) && (v_cnt == 10'd0);

    // Run/stop control and the raster counters; the stop only lands on the
    // last pixel of a frame so the counters wrap cleanly back to the origin.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    h_cnt <= '0;
                    v_cnt <= '0;
                    if (run) state <= RUN;
                end
                RUN, STOPPING: begin
                    if (h_last) begin
                        h_cnt <= '0;
                        v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
                    end else begin
                        h_cnt <= h_cnt + 11'd1;
                    end
                    if (run)
                        state <= RUN;
                    else if ((state == STOPPING) && h_last && v_last)
                        state <= IDLE;
                    else
                        state <= STOPPING;
                end
                default: begin
                    state <= IDLE;
                    h_cnt <= '0;
                    v_cnt <= '0;
                end
            endcase
        end
    end

    // Registered outputs, all decoded from the same counter/state snapshot
    // so coordinates, enable, syncs and pulses stay cycle-aligned.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gr_x        <= '0;
            gr_y        <= '0;
            enable      <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            gr_x        <= h_cnt;
            gr_y        <= v_cnt;
            enable      <= scanning && (h_cnt < H_ACT) && (v_cnt < V_ACT);
            hsync       <= (scanning && (h_cnt >= H_SYNC_S) && (h_cnt < H_SYNC_E))
                           ? SYNC_POL : ~SYNC_POL;
            vsync       <= (scanning && (v_cnt >= V_SYNC_S) && (v_cnt < V_SYNC_E))
                           ? SYNC_POL : ~SYNC_POL;
            line_start  <= scanning && (h_cnt == 11'd0) && (v_cnt < V_ACT);
            frame_start <= at_origin;
            busy        <= scanning;
        end
    end

`ifdef VGA_RASTER_FRAME_CNT_EN
    // Frame counter steps together with the registered frame_start pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            frame_cnt <= '0;
        else if (at_origin)
            frame_cnt <= frame_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_vga_raster_gen.sv
// tb_vga_raster_gen: directed bench for vga_raster_gen using a reduced
// timing set (32 x 18 total, 576 clks per frame) so whole frames fit easily.
// With VGA_RASTER_FRAME_CNT_EN defined, a tiny 5 x 5 instance also checks
// the frame counter wrap.

module tb_vga_raster_gen;

    localparam int H_ACTIVE = 20;
    localparam int H_FP     = 4;
    localparam int H_SYNC   = 6;
    localparam int H_BP     = 2;
    localparam int V_ACTIVE = 12;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 3;
    localparam int FRAME    = 32 * 18;

    logic        clk;
    logic        reset;
    logic        run;
    logic [10:0] gr_x;
    logic [9:0]  gr_y;
    logic        enable;
    logic        hsync;
    logic        vsync;
    logic        line_start;
    logic        frame_start;
    logic        busy;

    int checks;
    int failures;
    int cyc;

`ifdef VGA_RASTER_FRAME_CNT_EN
    logic [7:0]  frame_cnt;
    logic        run2;
    logic [10:0] t_gr_x;
    logic [9:0]  t_gr_y;
    logic        t_enable;
    logic        t_hsync;
    logic        t_vsync;
    logic        t_line_start;
    logic        t_frame_start;
    logic        t_busy;
    logic [7:0]  t_frame_cnt;
`endif

    vga_raster_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .SYNC_POL(1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .gr_x       (gr_x),
        .gr_y       (gr_y),
        .enable     (enable),
        .hsync      (hsync),
        .vsync      (vsync),
        .line_start (line_start),
        .frame_start(frame_start),
        .busy       (busy)
`ifdef VGA_RASTER_FRAME_CNT_EN
        ,
        .frame_cnt  (frame_cnt)
`endif
    );

`ifdef VGA_RASTER_FRAME_CNT_EN
    vga_raster_gen #(
        .H_ACTIVE(2), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b1)
    ) dut_tiny (
        .clk        (clk),
        .reset      (reset),
        .run        (run2),
        .gr_x       (t_gr_x),
        .gr_y       (t_gr_y),
        .enable     (t_enable),
        .hsync      (t_hsync),
        .vsync      (t_vsync),
        .line_start (t_line_start),
        .frame_start(t_frame_start),
        .busy       (t_busy),
        .frame_cnt  (t_frame_cnt)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_xy(input int x, input int y, output int n);
        n = 0;
        while (!((32'(gr_x) == x) && (32'(gr_y) == y)) && (n < 2 * FRAME)) begin
            tick();
            n++;
        end
        if (n >= 2 * FRAME) chk("wait_xy_timeout", 32'(n), 0);
    endtask

    task automatic wait_fs(output int n);
        n = 0;
        while (!frame_start && (n < 2 * FRAME)) begin
            tick();
            n++;
        end
        if (n >= 2 * FRAME) chk("wait_fs_timeout", 32'(n), 0);
    endtask

    initial begin
        int n;
        int t0;
        checks   = 0;
        failures = 0;
        cyc      = 0;
        reset    = 1'b0;
        run      = 1'b0;
`ifdef VGA_RASTER_FRAME_CNT_EN
        run2     = 1'b0;
`endif
        repeat (3) tick();

        // reset state
        chk("rst_gr_x", 32'(gr_x), 0);
        chk("rst_gr_y", 32'(gr_y), 0);
        chk("rst_enable", 32'(enable), 0);
        chk("rst_hsync", 32'(hsync), 0);
        chk("rst_vsync", 32'(vsync), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_fs", 32'(frame_start), 0);
        chk("rst_ls", 32'(line_start), 0);

        // release with run=1: frame_start two clocks later
        reset = 1'b1;
        run   = 1'b1;
        tick();
        chk("start_c1_fs", 32'(frame_start), 0);
        chk("start_c1_busy", 32'(busy), 0);
        tick();
        chk("start_c2_fs", 32'(frame_start), 1);
        chk("start_c2_x", 32'(gr_x), 0);
        chk("start_c2_y", 32'(gr_y), 0);
        chk("start_c2_en", 32'(enable), 1);
        chk("start_c2_ls", 32'(line_start), 1);
        chk("start_c2_busy", 32'(busy), 1);
`ifdef VGA_RASTER_FRAME_CNT_EN
        chk("fcnt_first", 32'(frame_cnt), 1);
`endif
        t0 = cyc;

        // horizontal segments
        wait_xy(19, 0, n);
        chk("en_last_active", 32'(enable), 1);
        tick();
        chk("en_fall_x", 32'(gr_x), 20);
        chk("en_fall", 32'(enable), 0);
        wait_xy(23, 0, n);
        chk("hs_before", 32'(hsync), 0);
        tick();
        chk("hs_first", 32'(hsync), 1);
        wait_xy(29, 0, n);
        chk("hs_last", 32'(hsync), 1);
        tick();
        chk("hs_after", 32'(hsync), 0);
        wait_xy(0, 1, n);
        chk("line1_delay", 32'(cyc - t0), 32);
        chk("line1_ls", 32'(line_start), 1);

        // vertical segments
        wait_xy(0, 11, n);
        chk("y11_en", 32'(enable), 1);
        chk("y11_ls", 32'(line_start), 1);
        wait_xy(0, 12, n);
        chk("y12_en", 32'(enable), 0);
        chk("y12_ls", 32'(line_start), 0);
        chk("y12_vs", 32'(vsync), 0);
        wait_xy(0, 13, n);
        chk("y13_vs", 32'(vsync), 1);
        wait_xy(0, 14, n);
        chk("y14_vs", 32'(vsync), 1);
        wait_xy(0, 15, n);
        chk("y15_vs", 32'(vsync), 0);
        wait_fs(n);
        chk("frame_period", 32'(cyc - t0), FRAME);
`ifdef VGA_RASTER_FRAME_CNT_EN
        chk("fcnt_second", 32'(frame_cnt), 2);
`endif

        // drop run mid-frame: scan completes then idles
        wait_xy(0, 6, n);
        run = 1'b0;
        tick();
        chk("stop_busy", 32'(busy), 1);
        wait_xy(31, 17, n);
        chk("stop_last_busy", 32'(busy), 1);
        tick();
        chk("idle_x", 32'(gr_x), 0);
        chk("idle_y", 32'(gr_y), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_fs", 32'(frame_start), 0);
        tick();
        chk("idle_en", 32'(enable), 0);
        chk("idle_hs", 32'(hsync), 0);
`ifdef VGA_RASTER_FRAME_CNT_EN
        chk("fcnt_idle_hold", 32'(frame_cnt), 2);
`endif

        // restart, drop and re-raise run inside the frame: no gap
        run = 1'b1;
        tick();
        chk("restart_c1_fs", 32'(frame_start), 0);
        tick();
        chk("restart_c2_fs", 32'(frame_start), 1);
        t0 = cyc;
        wait_xy(0, 4, n);
        run = 1'b0;
        wait_xy(0, 9, n);
        chk("stopping_busy", 32'(busy), 1);
        run = 1'b1;
        wait_fs(n);
        chk("rerun_period", 32'(cyc - t0), FRAME);

        // asynchronous reset mid-frame while both syncs are active
        wait_xy(25, 13, n);
        chk("pre_rst_hs", 32'(hsync), 1);
        chk("pre_rst_vs", 32'(vsync), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_x", 32'(gr_x), 0);
        chk("midrst_y", 32'(gr_y), 0);
        chk("midrst_hs", 32'(hsync), 0);
        chk("midrst_vs", 32'(vsync), 0);
        chk("midrst_busy", 32'(busy), 0);
`ifdef VGA_RASTER_FRAME_CNT_EN
        chk("midrst_fcnt", 32'(frame_cnt), 0);
`endif
        reset = 1'b1;
        tick();
        chk("rerel_c1_fs", 32'(frame_start), 0);
        tick();
        chk("rerel_c2_fs", 32'(frame_start), 1);
        chk("rerel_c2_x", 32'(gr_x), 0);
        chk("rerel_c2_y", 32'(gr_y), 0);
`ifdef VGA_RASTER_FRAME_CNT_EN
        chk("rerel_fcnt", 32'(frame_cnt), 1);

        // frame counter wrap on the tiny instance (25 clks per frame)
        begin
            int nfs;
            int k;
            nfs  = 0;
            k    = 0;
            run2 = 1'b1;
            while ((nfs < 256) && (k < 20000)) begin
                tick();
                k++;
                if (t_frame_start) begin
                    nfs++;
                    if (nfs == 3) begin
                        chk("tiny_fcnt_3", 32'(t_frame_cnt), 3);
                        chk("tiny_x", 32'(t_gr_x), 0);
                        chk("tiny_y", 32'(t_gr_y), 0);
                        chk("tiny_en", 32'(t_enable), 1);
                        chk("tiny_ls", 32'(t_line_start), 1);
                        chk("tiny_hs", 32'(t_hsync), 0);
                        chk("tiny_vs", 32'(t_vsync), 0);
                        chk("tiny_busy", 32'(t_busy), 1);
                    end
                    if (nfs == 256) chk("tiny_fcnt_wrap", 32'(t_frame_cnt), 0);
                end
            end
            if (nfs < 256) chk("tiny_timeout", 32'(nfs), 256);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
